axis_pattern_source: RTL and testbench

//  AXI4-Stream transmitter that plays a host-loaded pattern memory out as framed beats. It is the

---
 rtl/axis_pattern_source.sv | 168 ++++++++++++++++
 tb/tb_axis_pattern_source.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_source.sv
// AXI4-Stream master that replays a host-loaded pattern memory as framed beats,
// with a finite/infinite loop count, frame-aligned stop and a two-entry output skid.
module axis_pattern_source #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int LOOP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [LOOP_WIDTH-1:0] loops,
  output logic                  busy,
  output logic                  done,
  output logic [LOOP_WIDTH-1:0] frames,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data, r_sk_data, r_tdata;
  logic [ADDR_WIDTH-1:0] r_rd_addr, r_last_addr;
  logic [LOOP_WIDTH-1:0] r_loops, r_iss_frames, r_frames;
  logic                  r_rd_vld, r_rd_last, r_sk_vld, r_sk_last, r_tvalid, r_tlast;
  logic                  r_stop_seen, r_busy, r_done;

  logic       w_pop, w_start, w_issue, w_at_last, w_final_frame, w_final_hs;
  logic [1:0] w_occ;

  // FSM state register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN; else w_next = S_IDLE;
      S_RUN:   if (w_issue && w_at_last && w_final_frame) w_next = S_DRAIN; else w_next = S_RUN;
      S_DRAIN: if (w_final_hs) w_next = S_IDLE; else w_next = S_DRAIN;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: read issue is credit-limited so skid + in-flight never exceed two beats
  always_comb begin
    w_pop         = r_tvalid & m_tready;
    w_occ         = {1'b0, r_tvalid} + {1'b0, r_sk_vld};
    w_start       = (r_state == S_IDLE) & start;
    w_at_last     = (r_rd_addr == r_last_addr);
    w_final_frame = r_stop_seen | stop |
                    ((r_loops != '0) && ((r_iss_frames + LOOP_WIDTH'(1)) == r_loops));
    w_issue       = (r_state == S_RUN) &&
                    (({1'b0, w_occ} + {2'b0, r_rd_vld} - {2'b0, w_pop}) < 3'd2);
    w_final_hs    = (r_state == S_DRAIN) & w_pop & r_tlast & ~r_sk_vld & ~r_rd_vld;
  end

  // Pattern memory: synchronous write, synchronous read (old data on same-cycle collision)
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (w_issue) r_rd_data <= r_mem[r_rd_addr];
  end

  // Read address sequencing and latched playback configuration
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_addr    <= '0;
      r_last_addr  <= '0;
      r_loops      <= '0;
      r_iss_frames <= '0;
      r_rd_vld     <= 1'b0;
      r_rd_last    <= 1'b0;
      r_stop_seen  <= 1'b0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) r_rd_last <= w_at_last;
      if (w_start) begin
        r_last_addr  <= last_addr;
        r_loops      <= loops;
        r_rd_addr    <= '0;
        r_iss_frames <= '0;
        r_stop_seen  <= 1'b0;
      end else begin
        if (stop && r_state == S_RUN) r_stop_seen <= 1'b1;
        if (w_issue) begin
          if (w_at_last) begin
            r_rd_addr    <= '0;
            r_iss_frames <= r_iss_frames + LOOP_WIDTH'(1);
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
          end
        end
      end
    end
  end

  // Output register plus skid entry, kept in order as a two-deep FIFO
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_tlast   <= 1'b0;
      r_sk_vld  <= 1'b0;
      r_sk_data <= '0;
      r_sk_last <= 1'b0;
    end else if (w_pop || !r_tvalid) begin
      if (r_sk_vld) begin
        r_tvalid <= 1'b1;
        r_tdata  <= r_sk_data;
        r_tlast  <= r_sk_last;
        r_sk_vld <= r_rd_vld;
        if (r_rd_vld) begin
          r_sk_data <= r_rd_data;
          r_sk_last <= r_rd_last;
        end
      end else if (r_rd_vld) begin
        r_tvalid <= 1'b1;
        r_tdata  <= r_rd_data;
        r_tlast  <= r_rd_last;
      end else begin
        r_tvalid <= 1'b0;
      end
    end else if (r_rd_vld) begin
      r_sk_vld  <= 1'b1;
      r_sk_data <= r_rd_data;
      r_sk_last <= r_rd_last;
    end
  end

  // Status: busy window, completion pulse and frame counter
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_frames <= '0;
    end else begin
      r_done <= w_final_hs;
      if (w_start)         r_busy <= 1'b1;
      else if (w_final_hs) r_busy <= 1'b0;
      if (w_start)                r_frames <= '0;
      else if (w_pop && r_tlast)  r_frames <= r_frames + LOOP_WIDTH'(1);
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign frames   = r_frames;
  assign m_tdata  = r_tdata;
  assign m_tvalid = r_tvalid;
  assign m_tlast  = r_tlast;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Self-checking bench for axis_pattern_source: expected beat stream is built from the
// pattern contents and frame rules, then compared on every handshake.
module tb_axis_pattern_source;
  localparam int DW = 128;
  localparam int AW = 10;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start, stop;
  logic [AW-1:0] last_addr;
  logic [LW-1:0] loops;
  logic          busy, done;
  logic [LW-1:0] frames;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;

  axis_pattern_source #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOOP_WIDTH(LW)) dut (
    .clk(clk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .last_addr(last_addr), .loops(loops),
    .busy(busy), .done(done), .frames(frames),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_d [$];
  logic          exp_l [$];
  int cyc = 0, first_hs, last_hs, beats_seen, done_cnt;
  int ready_pct = 100, hold_left = 0, stop_at = -1, restart_at = -1;
  logic          held_v = 1'b0, held_l;
  logic [DW-1:0] held_d;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic mem_write(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d; ref_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic expect_frames(input int last, input int nfr);
    for (int f = 0; f < nfr; f++)
      for (int a = 0; a <= last; a++) begin
        exp_d.push_back(ref_mem[a]);
        exp_l.push_back(a == last);
      end
  endtask

  // One cycle: stall stability, ready choice, handshake comparison, stop/restart drive
  task automatic step();
    logic hs;
    @(negedge clk);
    cyc++;
    if (held_v) begin
      check("stall_valid", m_tvalid, 1);
      check("stall_data", m_tdata, held_d);
      check("stall_last", m_tlast, held_l);
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("busy_at_done", busy, 0);
    end
    if (m_tvalid === 1'b1 && hold_left > 0) begin
      m_tready = 1'b0;
      hold_left--;
    end else begin
      m_tready = ($urandom_range(99) < ready_pct);
    end
    hs = m_tvalid & m_tready;
    if (hs) begin
      if (exp_d.size() == 0) check("extra_beat", 1, 0);
      else begin
        check("beat_data", m_tdata, exp_d.pop_front());
        check("beat_last", m_tlast, exp_l.pop_front());
      end
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      beats_seen++;
    end
    held_v = m_tvalid & ~m_tready;
    held_d = m_tdata;
    held_l = m_tlast;
    stop  = hs && (beats_seen - 1 == stop_at);
    start = (restart_at >= 0) && (beats_seen >= restart_at) && (exp_d.size() > 0);
  endtask

  task automatic play(input int last, input int lp, input int nfr, input int pct,
                      input int stop_i, input int restart_i);
    logic [DW-1:0] w0;
    int budget, total;
    exp_d.delete(); exp_l.delete();
    expect_frames(last, nfr);
    total = exp_d.size();
    ready_pct = pct; stop_at = stop_i; restart_at = restart_i;
    beats_seen = 0; done_cnt = 0; first_hs = -1; last_hs = -1;
    w0 = ref_mem[0];
    @(negedge clk);
    last_addr = last[AW-1:0]; loops = lp[LW-1:0]; start = 1'b1;
    step();
    check("busy_after_start", busy, 1);
    check("frames_cleared", frames, 0);
    check("lat_c1", m_tvalid, 0);
    last_addr = ~last_addr;
    loops = loops + 16'd3;
    step();
    check("lat_c2", m_tvalid, 0);
    step();
    check("lat_c3_valid", m_tvalid, 1);
    check("lat_c3_word0", m_tdata, w0);
    budget = 3000;
    while (done_cnt == 0 && budget > 0) begin
      step();
      budget--;
    end
    check("done_seen", done_cnt, 1);
    repeat (3) step();
    check("done_once", done_cnt, 1);
    check("idle_valid", m_tvalid, 0);
    check("idle_busy", busy, 0);
    check("frames", frames, nfr);
    check("queue_empty", exp_d.size(), 0);
    if (pct == 100) check("no_bubbles", last_hs - first_hs, total - 1);
  endtask

  initial begin
    aresetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; last_addr = '0; loops = '0; m_tready = 1'b0;
    #2;
    check("rst_valid", m_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frames", frames, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    repeat (3) @(negedge clk);
    aresetn = 1'b1;

    for (int a = 0; a < 16; a++) mem_write(a, {$urandom, $urandom, $urandom, $urandom});

    play(7, 2, 2, 100, -1, -1);     // full rate, two frames
    play(7, 2, 2, 50, -1, -1);      // random backpressure
    play(7, 0, 2, 100, 10, -1);     // infinite, stop on beat 3 of frame 2
    mem_write(0, 128'hA5);
    play(0, 4, 4, 60, -1, -1);      // one-word frames
    hold_left = 100;
    play(7, 1, 1, 100, -1, -1);     // long initial stall
    play(7, 2, 2, 50, -1, 5);       // start re-pulsed while busy

    // Reset in the middle of the second frame of an infinite run
    exp_d.delete(); exp_l.delete();
    expect_frames(7, 3);
    ready_pct = 100; hold_left = 0; stop_at = -1; restart_at = -1;
    beats_seen = 0; done_cnt = 0; first_hs = -1;
    @(negedge clk);
    last_addr = 10'd7; loops = 16'd0; start = 1'b1;
    repeat (14) step();
    check("pre_reset_frames", frames, 1);
    #1 aresetn = 1'b0;
    #1;
    check("midrst_valid", m_tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frames", frames, 0);
    held_v = 1'b0;
    exp_d.delete(); exp_l.delete();
    @(negedge clk);
    aresetn = 1'b1;
    play(7, 1, 1, 100, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
